// File: rtl/traffic_light_monitor_if.sv
// Observed light codes and clear in; sticky error flags and phase counter out.
interface traffic_light_monitor_if;
    logic [1:0]  ns_light;
    logic [1:0]  ew_light;
    logic [1:0]  sn_light;
    logic [1:0]  we_light;
    logic        clear_err;
    logic        err_conflict;
    logic        err_sequence;
    logic        err_dwell;
    logic        err_starve;
    logic        err_any;
    logic [3:0]  first_err;
    logic [15:0] phase_count;

    modport master (
        output ns_light, ew_light, sn_light, we_light, clear_err,
        input  err_conflict, err_sequence, err_dwell, err_starve, err_any,
               first_err, phase_count
    );

    modport slave (
        input  ns_light, ew_light, sn_light, we_light, clear_err,
        output err_conflict, err_sequence, err_dwell, err_starve, err_any,
               first_err, phase_count
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Intersection light checker: flags set on the sampling edge, err_any one edge later.
// No backpressure: every rising edge judges all four directions.
module traffic_light_monitor #(
    parameter int MIN_GREEN  = 10,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_RED    = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_light_monitor_if.slave  mon
);
    localparam logic [1:0]  RED = 2'b00;
    localparam logic [1:0]  YEL = 2'b01;
    localparam logic [1:0]  GRN = 2'b10;
    localparam logic [15:0] MIN_GREEN_W  = 16'(MIN_GREEN);
    localparam logic [15:0] MIN_YELLOW_W = 16'(MIN_YELLOW);
    localparam logic [15:0] MAX_RED_W    = 16'(MAX_RED);

    // Direction index: 0 ns, 1 ew, 2 sn, 3 we
    logic [1:0]  light     [4];
    logic [1:0]  prev_q    [4];
    logic [15:0] dwell_q   [4];
    logic [15:0] dwell_nxt [4];

    logic [3:0]  seq_dir;
    logic [3:0]  dwell_dir;
    logic [3:0]  starve_dir;
    logic [3:0]  y2r_dir;
    logic [2:0]  y2r_cnt;
    logic        conflict;
    logic [3:0]  det;
    logic [3:0]  flag_q;
    logic [3:0]  flag_nxt;
    logic [3:0]  first_q;
    logic [3:0]  first_nxt;
    logic        err_any_q;
    logic [15:0] phase_q;
    logic [15:0] phase_nxt;
    logic [16:0] phase_sum;

    assign light[0] = mon.ns_light;
    assign light[1] = mon.ew_light;
    assign light[2] = mon.sn_light;
    assign light[3] = mon.we_light;

    always_comb begin
        seq_dir    = '0;
        dwell_dir  = '0;
        starve_dir = '0;
        y2r_dir    = '0;
        y2r_cnt    = '0;
        for (int i = 0; i < 4; i++) begin
            dwell_nxt[i] = 16'd1;
            case ({prev_q[i], light[i]})
                {RED, RED}, {RED, GRN}, {GRN, GRN},
                {GRN, YEL}, {YEL, YEL}, {YEL, RED}: seq_dir[i] = 1'b0;
                default:                            seq_dir[i] = 1'b1;
            endcase
            y2r_dir[i]    = (prev_q[i] == YEL) && (light[i] == RED);
            // Dwell limits are checked against the count held before this sample
            dwell_dir[i]  = ((prev_q[i] == GRN) && (light[i] == YEL) && (dwell_q[i] < MIN_GREEN_W)) ||
                            (y2r_dir[i] && (dwell_q[i] < MIN_YELLOW_W));
            starve_dir[i] = (prev_q[i] == RED) && (light[i] == RED) && (dwell_q[i] == MAX_RED_W);
            if (light[i] == prev_q[i]) begin
                dwell_nxt[i] = (dwell_q[i] == 16'hFFFF) ? dwell_q[i] : dwell_q[i] + 16'd1;
            end
            y2r_cnt = y2r_cnt + {2'b00, y2r_dir[i]};
        end
    end

    // Any non-red (including illegal 11) on one axis against any non-red on the other
    assign conflict = ((light[0] != RED) || (light[2] != RED)) &&
                      ((light[1] != RED) || (light[3] != RED));

    assign det = {|starve_dir, |dwell_dir, |seq_dir, conflict};

    always_comb begin
        flag_nxt  = flag_q | det;
        first_nxt = first_q;
        if (mon.clear_err) begin
            flag_nxt  = det;
            first_nxt = det;
        end else if (first_q == 4'd0) begin
            first_nxt = det;
        end
    end

    assign phase_sum = {1'b0, phase_q} + {14'd0, y2r_cnt};
    assign phase_nxt = phase_sum[16] ? 16'hFFFF : phase_sum[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                prev_q[i]  <= RED;
                dwell_q[i] <= '0;
            end
            flag_q    <= '0;
            first_q   <= '0;
            err_any_q <= 1'b0;
            phase_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                prev_q[i]  <= light[i];
                dwell_q[i] <= dwell_nxt[i];
            end
            flag_q    <= flag_nxt;
            first_q   <= first_nxt;
            err_any_q <= |flag_q;
            phase_q   <= phase_nxt;
        end
    end

    assign mon.err_conflict = flag_q[0];
    assign mon.err_sequence = flag_q[1];
    assign mon.err_dwell    = flag_q[2];
    assign mon.err_starve   = flag_q[3];
    assign mon.err_any      = err_any_q;
    assign mon.first_err    = first_q;
    assign mon.phase_count  = phase_q;
endmodule
